// File: rtl/cardinal_router.sv
// cardinal_router: 5-port mesh router node (up/down/left/right/NIC) with 64-bit flits,
// X-first dimension-ordered routing, a 1-flit buffer on every input and output, and
// a round-robin switch arbiter per output.
module cardinal_router (
  input  logic        clk,
  input  logic        reset,

  input  logic        up_si,
  input  logic [63:0] up_di,
  output logic        up_ri,
  output logic        up_so,
  output logic [63:0] up_do,
  input  logic        up_ro,

  input  logic        down_si,
  input  logic [63:0] down_di,
  output logic        down_ri,
  output logic        down_so,
  output logic [63:0] down_do,
  input  logic        down_ro,

  input  logic        left_si,
  input  logic [63:0] left_di,
  output logic        left_ri,
  output logic        left_so,
  output logic [63:0] left_do,
  input  logic        left_ro,

  input  logic        right_si,
  input  logic [63:0] right_di,
  output logic        right_ri,
  output logic        right_so,
  output logic [63:0] right_do,
  input  logic        right_ro,

  input  logic        NIC_si,
  input  logic [63:0] NIC_di,
  output logic        NIC_ri,
  output logic        NIC_so,
  output logic [63:0] NIC_do,
  input  logic        NIC_ro,

  output logic        polarity_to_NIC
);

  localparam int unsigned NP     = 5;   // ports
  localparam int unsigned NR     = 4;   // requesters per output / targets per input
  localparam int unsigned FW     = 64;  // flit width
  localparam int unsigned HW     = 4;   // hop field width
  localparam int unsigned PW     = 3;   // port index width
  localparam int unsigned SW     = 2;   // requester slot width
  localparam int unsigned XDIR_B = 62;
  localparam int unsigned YDIR_B = 61;
  localparam int unsigned HX_LSB = 52;
  localparam int unsigned HY_LSB = 48;

  localparam logic [PW-1:0] P_UP    = PW'(0);
  localparam logic [PW-1:0] P_DOWN  = PW'(1);
  localparam logic [PW-1:0] P_LEFT  = PW'(2);
  localparam logic [PW-1:0] P_RIGHT = PW'(3);
  localparam logic [PW-1:0] P_NIC   = PW'(4);

  // Port bundles, indexed up=0, down=1, left=2, right=3, NIC=4
  logic [NP-1:0]         si;
  logic [NP-1:0]         ro;
  logic [NP-1:0][FW-1:0] di;

  assign si = {NIC_si, right_si, left_si, down_si, up_si};
  assign ro = {NIC_ro, right_ro, left_ro, down_ro, up_ro};
  assign di = {NIC_di, right_di, left_di, down_di, up_di};

  // State
  logic [NP-1:0]         in_empty_q, in_empty_d;
  logic [NP-1:0][FW-1:0] in_flit_q,  in_flit_d;
  logic [NP-1:0]         out_v_q,    out_v_d;
  logic [NP-1:0][FW-1:0] out_flit_q, out_flit_d;
  logic [NP-1:0][SW-1:0] ptr_q,      ptr_d;
  logic                  pol_q,      pol_d;

  // Datapath / control
  logic [NP-1:0][PW-1:0] dst;
  logic [NP-1:0][FW-1:0] fwd;
  logic [NP-1:0][NR-1:0] sel;
  logic [NP-1:0]         drop;
  logic [NP-1:0][NR-1:0] req;
  logic [NP-1:0]         gnt_v;
  logic [NP-1:0][SW-1:0] gnt_slot;
  logic [NP-1:0][PW-1:0] gnt_src;
  logic [SW-1:0]         arb_slot;
  logic [NP-1:0]         take;

  // Route each buffered flit X-first; a would-be U-turn falls back to NIC unmodified
  always_comb begin
    dst = '0;
    fwd = '0;
    for (int i = 0; i < NP; i++) begin
      dst[i] = P_NIC;
      fwd[i] = in_flit_q[i];
      if (in_flit_q[i][HX_LSB +: HW] != '0) begin
        dst[i] = in_flit_q[i][XDIR_B] ? P_LEFT : P_RIGHT;
        fwd[i][HX_LSB +: HW] = in_flit_q[i][HX_LSB +: HW] - HW'(1);
      end else if (in_flit_q[i][HY_LSB +: HW] != '0) begin
        dst[i] = in_flit_q[i][YDIR_B] ? P_DOWN : P_UP;
        fwd[i][HY_LSB +: HW] = in_flit_q[i][HY_LSB +: HW] - HW'(1);
      end
      if (dst[i] == PW'(i)) begin
        dst[i] = P_NIC;
        fwd[i] = in_flit_q[i];
      end
    end
  end

  // One-hot target select over the four non-own outputs; a NIC flit with no hops left
  // has no legal output and is discarded rather than blocking the NIC input forever
  always_comb begin
    sel  = '0;
    drop = '0;
    for (int i = 0; i < NP; i++) begin
      if (!in_empty_q[i]) begin
        if (dst[i] == PW'(i)) begin
          drop[i] = 1'b1;
        end else if (dst[i] < PW'(i)) begin
          sel[i][SW'(dst[i])] = 1'b1;
        end else begin
          sel[i][SW'(dst[i] - PW'(1))] = 1'b1;
        end
      end
    end
  end

  // Per-output request vector: slot s maps to the s-th input that is not this output
  always_comb begin
    req = '0;
    for (int o = 0; o < NP; o++) begin
      for (int s = 0; s < NR; s++) begin
        req[o][s] = sel[(s < o) ? s : s + 1][(o < ((s < o) ? s : s + 1)) ? o : o - 1];
      end
    end
  end

  // Round-robin arbitration, granting only when the output buffer is empty or draining
  always_comb begin
    gnt_v    = '0;
    gnt_slot = '0;
    gnt_src  = '0;
    ptr_d    = ptr_q;
    arb_slot = '0;
    for (int o = 0; o < NP; o++) begin
      if (!out_v_q[o] || ro[o]) begin
        for (int k = 0; k < NR; k++) begin
          arb_slot = ptr_q[o] + SW'(k);
          if (!gnt_v[o] && req[o][arb_slot]) begin
            gnt_v[o]    = 1'b1;
            gnt_slot[o] = arb_slot;
          end
        end
      end
      if (gnt_v[o]) begin
        gnt_src[o] = PW'(gnt_slot[o]) + ((PW'(gnt_slot[o]) < PW'(o)) ? PW'(0) : PW'(1));
        ptr_d[o]   = gnt_slot[o] + SW'(1);
      end
    end
  end

  // Buffer updates: switch transfer, output drain, input capture, polarity toggle
  always_comb begin
    in_empty_d = in_empty_q;
    in_flit_d  = in_flit_q;
    out_v_d    = out_v_q;
    out_flit_d = out_flit_q;
    pol_d      = ~pol_q;
    take       = '0;
    for (int o = 0; o < NP; o++) begin
      if (gnt_v[o]) begin
        out_v_d[o]       = 1'b1;
        out_flit_d[o]    = fwd[gnt_src[o]];
        take[gnt_src[o]] = 1'b1;
      end else if (out_v_q[o] && ro[o]) begin
        out_v_d[o] = 1'b0;
      end
    end
    for (int i = 0; i < NP; i++) begin
      if (take[i] || drop[i]) begin
        in_empty_d[i] = 1'b1;
      end else if (in_empty_q[i] && si[i]) begin
        in_empty_d[i] = 1'b0;
        in_flit_d[i]  = di[i];
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_empty_q <= '1;
      in_flit_q  <= '0;
      out_v_q    <= '0;
      out_flit_q <= '0;
      ptr_q      <= '0;
      pol_q      <= 1'b0;
    end else begin
      in_empty_q <= in_empty_d;
      in_flit_q  <= in_flit_d;
      out_v_q    <= out_v_d;
      out_flit_q <= out_flit_d;
      ptr_q      <= ptr_d;
      pol_q      <= pol_d;
    end
  end

  assign up_ri    = in_empty_q[P_UP];
  assign down_ri  = in_empty_q[P_DOWN];
  assign left_ri  = in_empty_q[P_LEFT];
  assign right_ri = in_empty_q[P_RIGHT];
  assign NIC_ri   = in_empty_q[P_NIC];

  assign up_so    = out_v_q[P_UP];
  assign down_so  = out_v_q[P_DOWN];
  assign left_so  = out_v_q[P_LEFT];
  assign right_so = out_v_q[P_RIGHT];
  assign NIC_so   = out_v_q[P_NIC];

  assign up_do    = out_flit_q[P_UP];
  assign down_do  = out_flit_q[P_DOWN];
  assign left_do  = out_flit_q[P_LEFT];
  assign right_do = out_flit_q[P_RIGHT];
  assign NIC_do   = out_flit_q[P_NIC];

  assign polarity_to_NIC = pol_q;

endmodule

// File: tb/tb_cardinal_router.sv
// Bench for cardinal_router: directed routing cases with literal expectations,
// output contention, randomized traffic and a mid-run asynchronous reset, all
// checked against a behavioural router model every cycle.
`timescale 1ns/1ps
module tb_cardinal_router;

  localparam int UP = 0;
  localparam int DN = 1;
  localparam int LF = 2;
  localparam int RT = 3;
  localparam int NC = 4;

  logic            clk   = 1'b0;
  logic            reset = 1'b1;
  logic [4:0]      si    = '0;
  logic [4:0]      ro    = '1;
  logic [4:0][63:0] di   = '0;
  logic [4:0]      ri_w;
  logic [4:0]      so_w;
  logic [4:0][63:0] do_w;
  logic            pol_w;

  always #5 clk = ~clk;

  cardinal_router dut (
    .clk(clk), .reset(reset),
    .up_si(si[UP]),    .up_di(di[UP]),    .up_ri(ri_w[UP]),    .up_so(so_w[UP]),    .up_do(do_w[UP]),    .up_ro(ro[UP]),
    .down_si(si[DN]),  .down_di(di[DN]),  .down_ri(ri_w[DN]),  .down_so(so_w[DN]),  .down_do(do_w[DN]),  .down_ro(ro[DN]),
    .left_si(si[LF]),  .left_di(di[LF]),  .left_ri(ri_w[LF]),  .left_so(so_w[LF]),  .left_do(do_w[LF]),  .left_ro(ro[LF]),
    .right_si(si[RT]), .right_di(di[RT]), .right_ri(ri_w[RT]), .right_so(so_w[RT]), .right_do(do_w[RT]), .right_ro(ro[RT]),
    .NIC_si(si[NC]),   .NIC_di(di[NC]),   .NIC_ri(ri_w[NC]),   .NIC_so(so_w[NC]),   .NIC_do(do_w[NC]),   .NIC_ro(ro[NC]),
    .polarity_to_NIC(pol_w)
  );

  // ---------------- behavioural model ----------------
  bit        m_in_v  [5];
  bit [63:0] m_in_d  [5];
  bit        m_out_v [5];
  bit [63:0] m_out_d [5];
  int        m_ptr   [5];
  bit        m_acc   [5];
  bit        m_pol;
  int        t_dst   [5];
  bit [63:0] t_fwd   [5];
  bit        n_in_v  [5];
  bit [63:0] n_in_d  [5];
  int        m_slot, m_src;
  bit        m_free, m_done;

  // Destination (-1 = discarded) and forwarded flit for a flit sitting in input src
  function automatic void route(input int src, input bit [63:0] f, output int dst, output bit [63:0] fo);
    int hx, hy;
    hx = int'(f[55:52]);
    hy = int'(f[51:48]);
    fo = f;
    if (hx > 0) begin
      dst = f[62] ? LF : RT;
      fo  = f - (64'd1 << 52);
    end else if (hy > 0) begin
      dst = f[61] ? DN : UP;
      fo  = f - (64'd1 << 48);
    end else begin
      dst = NC;
    end
    if (dst == src) begin
      dst = NC;
      fo  = f;
    end
    if (src == NC && dst == NC) dst = -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < 5; p++) begin
        m_in_v[p] = 1'b0; m_in_d[p] = '0; m_out_v[p] = 1'b0; m_out_d[p] = '0;
        m_ptr[p] = 0; m_acc[p] = 1'b0;
      end
      m_pol = 1'b0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        route(i, m_in_d[i], t_dst[i], t_fwd[i]);
        n_in_v[i] = m_in_v[i];
        n_in_d[i] = m_in_d[i];
      end
      for (int o = 0; o < 5; o++) begin
        m_free = !m_out_v[o] || ro[o];
        if (m_out_v[o] && ro[o]) m_out_v[o] = 1'b0;
        m_done = 1'b0;
        if (m_free) begin
          for (int k = 0; k < 4; k++) begin
            m_slot = (m_ptr[o] + k) % 4;
            m_src  = (m_slot < o) ? m_slot : m_slot + 1;
            if (!m_done && m_in_v[m_src] && t_dst[m_src] == o) begin
              m_done          = 1'b1;
              m_out_v[o]      = 1'b1;
              m_out_d[o]      = t_fwd[m_src];
              n_in_v[m_src]   = 1'b0;
              m_ptr[o]        = (m_slot + 1) % 4;
            end
          end
        end
      end
      for (int i = 0; i < 5; i++) begin
        if (m_in_v[i] && t_dst[i] < 0) n_in_v[i] = 1'b0;
        m_acc[i] = !m_in_v[i] && si[i];
        if (m_acc[i]) begin
          n_in_v[i] = 1'b1;
          n_in_d[i] = di[i];
        end
        m_in_v[i] = n_in_v[i];
        m_in_d[i] = n_in_d[i];
      end
      m_pol = !m_pol;
    end
  end

  // ---------------- compare process ----------------
  int          checks = 0;
  int          errors = 0;
  bit          lit_en = 1'b0;
  int          lit_sel = 0;
  logic [64:0] lit_exp = '0;
  string       lit_name = "";
  logic [64:0] lit_act;

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int p = 0; p < 5; p++) begin
      chk($sformatf("ri[%0d]", p), 65'(ri_w[p]), 65'(!m_in_v[p]));
      chk($sformatf("so[%0d]", p), 65'(so_w[p]), 65'(m_out_v[p]));
      if (m_out_v[p]) chk($sformatf("do[%0d]", p), 65'(do_w[p]), 65'(m_out_d[p]));
    end
    chk("polarity", 65'(pol_w), 65'(m_pol));
    if (lit_en) begin
      if (lit_sel < 5)       lit_act = {so_w[lit_sel], do_w[lit_sel]};
      else if (lit_sel == 5) lit_act = 65'(pol_w);
      else if (lit_sel == 6) lit_act = 65'(ri_w);
      else                   lit_act = 65'(so_w);
      chk(lit_name, lit_act, lit_exp);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
    lit_en = 1'b0;
  endtask

  // sel 0..4: {so,do} of that output; 5: polarity; 6: ri mask; 7: so mask
  task automatic expect_lit(input int sel, input logic [64:0] exp, input string nm);
    lit_en   = 1'b1;
    lit_sel  = sel;
    lit_exp  = exp;
    lit_name = nm;
  endtask

  task automatic send(input int ip, input bit [63:0] din, input int op, input bit [63:0] exp, input string nm);
    si[ip] = 1'b1;
    di[ip] = din;
    step();
    si[ip] = 1'b0;
    step();
    expect_lit(op, {1'b1, exp}, nm);
    step();
    step();
  endtask

  function automatic bit [63:0] rand_flit(input int p);
    bit [2:0]  dirs;
    bit [4:0]  rsv;
    bit [3:0]  hx, hy;
    bit [47:0] pl;
    dirs = 3'($urandom);
    rsv  = 5'($urandom);
    hx   = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 2));
    hy   = 4'($urandom_range(0, 2));
    if (p == NC && hx == 4'd0 && hy == 4'd0) hy = 4'd1;
    pl   = {16'($urandom), 32'($urandom)};
    return {dirs, rsv, hx, hy, pl};
  endfunction

  initial begin
    reset = 1'b1;
    si    = '0;
    ro    = '1;
    di    = '0;
    repeat (3) step();
    expect_lit(6, 65'h1F, "reset_ri");
    step();
    expect_lit(7, 65'h0, "reset_so");
    step();
    reset = 1'b0;
    step();
    expect_lit(5, 65'h1, "polarity_first");
    step();
    expect_lit(5, 65'h0, "polarity_second");
    step();

    send(DN, 64'h8002_0000_0000_0000, UP, 64'h8001_0000_0000_0000, "down_to_up");
    send(UP, 64'hA002_0000_0000_0000, DN, 64'hA001_0000_0000_0000, "up_to_down");
    send(LF, 64'hA031_0000_0000_0000, RT, 64'hA021_0000_0000_0000, "left_to_right");
    send(RT, 64'hC021_0000_0000_0000, LF, 64'hC011_0000_0000_0000, "right_to_left");
    send(NC, 64'hA022_0000_0000_0000, RT, 64'hA012_0000_0000_0000, "nic_to_right");
    send(DN, 64'h8000_DEAD_BEEF_CAFE, NC, 64'h8000_DEAD_BEEF_CAFE, "down_to_nic");
    send(UP, 64'h0001_0000_0000_0055, NC, 64'h0001_0000_0000_0055, "uturn_to_nic");
    send(LF, 64'h00F0_0000_0000_0001, RT, 64'h00E0_0000_0000_0001, "hop15_right");

    // Contention: left and right both want up while up is stalled
    ro[UP] = 1'b0;
    si[LF] = 1'b1; di[LF] = 64'h0001_0000_0000_0011;
    si[RT] = 1'b1; di[RT] = 64'h0001_0000_0000_0022;
    step();
    si[LF] = 1'b0;
    si[RT] = 1'b0;
    step();
    expect_lit(UP, {1'b1, 64'h0000_0000_0000_0011}, "contend_first");
    step();
    expect_lit(6, 65'h17, "contend_ri");
    step();
    expect_lit(UP, {1'b1, 64'h0000_0000_0000_0011}, "contend_hold");
    ro[UP] = 1'b1;
    step();
    expect_lit(UP, {1'b1, 64'h0000_0000_0000_0022}, "contend_second");
    step();
    expect_lit(7, 65'h0, "contend_done");
    step();

    // Random traffic with a mid-run asynchronous reset
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) begin
        reset = 1'b1;
        expect_lit(6, 65'h1F, "midreset_ri");
        step();
        expect_lit(7, 65'h0, "midreset_so");
        step();
        expect_lit(RT, 65'h0, "midreset_do");
        step();
        reset = 1'b0;
        step();
        expect_lit(5, 65'h1, "midreset_polarity");
      end
      for (int p = 0; p < 5; p++) begin
        ro[p] = ($urandom_range(0, 3) != 0);
        if (!si[p] || m_acc[p]) begin
          si[p] = ($urandom_range(0, 9) < 6);
          di[p] = rand_flit(p);
        end
      end
      step();
    end

    si = '0;
    ro = '1;
    repeat (10) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
